// File: rtl/route_comp_pipe_pkg.sv
// Shared constants for the route-compute pipeline: output port indices and
// a helper that assembles a productive-port vector.
package route_comp_pipe_pkg;

  localparam int P_GT_X   = 0;
  localparam int P_LT_X   = 1;
  localparam int P_GT_Y   = 2;
  localparam int P_LT_Y   = 3;
  localparam int P_LOCAL  = 4;
  localparam int NUM_PORT = 5;

  function automatic logic [NUM_PORT-1:0] make_prod(
    input logic gt_x,
    input logic lt_x,
    input logic gt_y,
    input logic lt_y
  );
    logic [NUM_PORT-1:0] p;
    p          = '0;
    p[P_GT_X]  = gt_x;
    p[P_LT_X]  = lt_x;
    p[P_GT_Y]  = gt_y;
    p[P_LT_Y]  = lt_y;
    p[P_LOCAL] = ~(gt_x | lt_x | gt_y | lt_y);
    return p;
  endfunction

endpackage

// File: rtl/route_comp_pipe_dir.sv
// Combinational single-dimension direction decision (greater / less / tie)
// for either plain mesh or torus wrap-around routing.
module route_dir_1d #(
  parameter int WIDTH_COORD = 3,
  parameter int MESH        = 8,
  parameter int TORUS       = 0
) (
  input  logic [WIDTH_COORD-1:0] pos,
  input  logic [WIDTH_COORD-1:0] dst,
  input  logic                   tie_bit,
  output logic                   gt,
  output logic                   lt,
  output logic                   tie
);

  localparam int DW = WIDTH_COORD + 2;
  localparam logic [DW-1:0] MESH_V = DW'(MESH);

  logic [WIDTH_COORD:0] delta;
  logic [DW-1:0]        raw;
  logic [DW-1:0]        fwd;
  logic [DW-1:0]        fwd2;

  always_comb begin
    gt    = 1'b0;
    lt    = 1'b0;
    tie   = 1'b0;
    delta = {1'b0, dst} - {1'b0, pos};
    // Forward distance modulo MESH; adding MESH first keeps it non-negative.
    raw   = {2'b00, dst} + MESH_V - {2'b00, pos};
    fwd   = (raw >= MESH_V) ? (raw - MESH_V) : raw;
    fwd2  = fwd << 1;
    if (TORUS == 0) begin
      lt = delta[WIDTH_COORD];
      gt = ~delta[WIDTH_COORD] && (delta != '0);
    end else if (fwd != '0) begin
      if (fwd2 < MESH_V) begin
        gt = 1'b1;
      end else if (fwd2 > MESH_V) begin
        lt = 1'b1;
      end else begin
        tie = 1'b1;
        lt  = tie_bit;
        gt  = ~tie_bit;
      end
    end
  end

endmodule

// File: rtl/route_comp_pipe.sv
// One-stage route-compute pipeline: per-channel productive-port vectors from
// packed destinations against a reconfigurable node position.
module route_comp_pipe
  import route_comp_pipe_pkg::*;
#(
  parameter int WIDTH_COORD = 3,
  parameter int NUM_CH      = 4,
  parameter int MESH_X      = 8,
  parameter int MESH_Y      = 8,
  parameter int TORUS       = 0,
  parameter int RST_POS_X   = 0,
  parameter int RST_POS_Y   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [WIDTH_COORD-1:0]        cfg_pos_x,
  input  logic [WIDTH_COORD-1:0]        cfg_pos_y,
  input  logic                          stall,
  input  logic [NUM_CH-1:0]             in_valid,
  input  logic [NUM_CH*WIDTH_COORD-1:0] in_dst_x,
  input  logic [NUM_CH*WIDTH_COORD-1:0] in_dst_y,
  output logic [NUM_CH-1:0]             out_valid,
  output logic [NUM_CH*NUM_PORT-1:0]    out_prod,
  output logic [NUM_CH-1:0]             out_err,
  output logic [WIDTH_COORD-1:0]        pos_x,
  output logic [WIDTH_COORD-1:0]        pos_y
);

  localparam int W = WIDTH_COORD;
  localparam logic [W:0] LIM_X = (W+1)'(MESH_X);
  localparam logic [W:0] LIM_Y = (W+1)'(MESH_Y);

  logic                       tie_bit;
  logic [NUM_CH*NUM_PORT-1:0] nxt_prod;
  logic [NUM_CH-1:0]          nxt_err;
  logic [NUM_CH-1:0]          ch_tie;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [W-1:0] dx;
    logic [W-1:0] dy;
    logic         x_gt, x_lt, x_tie;
    logic         y_gt, y_lt, y_tie;
    logic         in_range;
    logic         route_ok;

    assign dx = in_dst_x[ch*W +: W];
    assign dy = in_dst_y[ch*W +: W];

    route_dir_1d #(.WIDTH_COORD(W), .MESH(MESH_X), .TORUS(TORUS)) u_dir_x (
      .pos     (pos_x),
      .dst     (dx),
      .tie_bit (tie_bit),
      .gt      (x_gt),
      .lt      (x_lt),
      .tie     (x_tie)
    );

    route_dir_1d #(.WIDTH_COORD(W), .MESH(MESH_Y), .TORUS(TORUS)) u_dir_y (
      .pos     (pos_y),
      .dst     (dy),
      .tie_bit (tie_bit),
      .gt      (y_gt),
      .lt      (y_lt),
      .tie     (y_tie)
    );

    assign in_range = ({1'b0, dx} < LIM_X) && ({1'b0, dy} < LIM_Y);
    assign route_ok = in_valid[ch] && in_range;

    // Out-of-range flits report an error and never take part in tie-breaking.
    assign nxt_prod[ch*NUM_PORT +: NUM_PORT] =
      route_ok ? make_prod(x_gt, x_lt, y_gt, y_lt) : '0;
    assign nxt_err[ch] = in_valid[ch] && !in_range;
    assign ch_tie[ch]  = route_ok && (x_tie || y_tie);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= '0;
      out_prod  <= '0;
      out_err   <= '0;
      tie_bit   <= 1'b0;
      pos_x     <= W'(RST_POS_X);
      pos_y     <= W'(RST_POS_Y);
    end else begin
      if (cfg_we) begin
        pos_x <= cfg_pos_x;
        pos_y <= cfg_pos_y;
      end
      if (!stall) begin
        out_valid <= in_valid;
        out_prod  <= nxt_prod;
        out_err   <= nxt_err;
        if (|ch_tie) begin
          tie_bit <= ~tie_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_route_comp_pipe.sv
// Bench for route_comp_pipe: three instances (mesh 8x8, torus 8x8, torus 6x5)
// share stimulus and are checked against a distance-based reference model.
module tb_route_comp_pipe;

  localparam int W  = 3;
  localparam int NC = 4;
  localparam int ND = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [W-1:0]      cfg_pos_x;
  logic [W-1:0]      cfg_pos_y;
  logic              stall;
  logic [NC-1:0]     in_valid;
  logic [NC*W-1:0]   in_dst_x;
  logic [NC*W-1:0]   in_dst_y;

  logic [NC-1:0]     ov [ND];
  logic [NC*5-1:0]   op [ND];
  logic [NC-1:0]     oe [ND];
  logic [W-1:0]      px [ND];
  logic [W-1:0]      py [ND];

  int mx  [ND] = '{8, 8, 6};
  int my  [ND] = '{8, 8, 5};
  int tor [ND] = '{0, 1, 1};
  int rpx [ND] = '{0, 0, 2};
  int rpy [ND] = '{0, 0, 1};

  int            m_px [ND];
  int            m_py [ND];
  bit            m_tie [ND];
  logic [NC-1:0]   m_v [ND];
  logic [NC-1:0]   m_e [ND];
  logic [NC*5-1:0] m_p [ND];

  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  route_comp_pipe #(.WIDTH_COORD(W), .NUM_CH(NC)) dut_mesh (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pos_x(cfg_pos_x), .cfg_pos_y(cfg_pos_y),
    .stall(stall), .in_valid(in_valid), .in_dst_x(in_dst_x), .in_dst_y(in_dst_y),
    .out_valid(ov[0]), .out_prod(op[0]), .out_err(oe[0]), .pos_x(px[0]), .pos_y(py[0])
  );

  route_comp_pipe #(.WIDTH_COORD(W), .NUM_CH(NC), .TORUS(1)) dut_torus8 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pos_x(cfg_pos_x), .cfg_pos_y(cfg_pos_y),
    .stall(stall), .in_valid(in_valid), .in_dst_x(in_dst_x), .in_dst_y(in_dst_y),
    .out_valid(ov[1]), .out_prod(op[1]), .out_err(oe[1]), .pos_x(px[1]), .pos_y(py[1])
  );

  route_comp_pipe #(.WIDTH_COORD(W), .NUM_CH(NC), .MESH_X(6), .MESH_Y(5), .TORUS(1),
                    .RST_POS_X(2), .RST_POS_Y(1)) dut_torus6 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pos_x(cfg_pos_x), .cfg_pos_y(cfg_pos_y),
    .stall(stall), .in_valid(in_valid), .in_dst_x(in_dst_x), .in_dst_y(in_dst_y),
    .out_valid(ov[2]), .out_prod(op[2]), .out_err(oe[2]), .pos_x(px[2]), .pos_y(py[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Direction by shortest way round: compare forward distance with backward.
  task automatic dir_1d(input int d, input int p, input int m, input int torus, input bit tb,
                        output bit gt, output bit lt, output bit hit);
    int f;
    int back;
    gt = 0; lt = 0; hit = 0;
    if (torus == 0) begin
      gt = d > p;
      lt = d < p;
    end else begin
      f    = ((d - p) % m + m) % m;
      back = m - f;
      if (f != 0) begin
        if (f < back) gt = 1;
        else if (f > back) lt = 1;
        else begin
          hit = 1;
          if (tb) lt = 1; else gt = 1;
        end
      end
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      if (reset) begin
        m_px[d] = rpx[d]; m_py[d] = rpy[d]; m_tie[d] = 0;
        m_v[d] = '0; m_e[d] = '0; m_p[d] = '0;
      end else begin
        if (!stall) begin
          bit any_tie;
          any_tie = 0;
          for (int c = 0; c < NC; c++) begin
            int dx;
            int dy;
            bit xg, xl, xh, yg, yl, yh;
            dx = int'(in_dst_x[c*W +: W]);
            dy = int'(in_dst_y[c*W +: W]);
            m_v[d][c] = in_valid[c];
            m_e[d][c] = 1'b0;
            m_p[d][c*5 +: 5] = '0;
            if (in_valid[c]) begin
              if (dx >= mx[d] || dy >= my[d]) begin
                m_e[d][c] = 1'b1;
              end else begin
                dir_1d(dx, m_px[d], mx[d], tor[d], m_tie[d], xg, xl, xh);
                dir_1d(dy, m_py[d], my[d], tor[d], m_tie[d], yg, yl, yh);
                if (xh || yh) any_tie = 1;
                m_p[d][c*5 + 0] = xg;
                m_p[d][c*5 + 1] = xl;
                m_p[d][c*5 + 2] = yg;
                m_p[d][c*5 + 3] = yl;
                m_p[d][c*5 + 4] = (dx == m_px[d]) && (dy == m_py[d]);
              end
            end
          end
          if (any_tie) m_tie[d] = !m_tie[d];
        end
        if (cfg_we) begin
          m_px[d] = int'(cfg_pos_x);
          m_py[d] = int'(cfg_pos_y);
        end
      end
      exp_q.push_back({30'b0, 3'(m_py[d]), 3'(m_px[d]), m_e[d], m_v[d], m_p[d]});
    end
  endtask

  task automatic step();
    logic [63:0] got;
    model_edge();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      got = {30'b0, py[d], px[d], oe[d], ov[d], op[d]};
      check($sformatf("dut%0d_outputs", d), got, exp_q.pop_front());
    end
  endtask

  task automatic set_dst(input int c, input int x, input int y);
    in_dst_x[c*W +: W] = W'(x);
    in_dst_y[c*W +: W] = W'(y);
  endtask

  task automatic set_cfg(input bit we, input int x, input int y);
    cfg_we    = we;
    cfg_pos_x = W'(x);
    cfg_pos_y = W'(y);
  endtask

  initial begin
    // Reset overrides stall and cfg_we.
    reset = 1'b1; stall = 1'b1; set_cfg(1, 4, 4);
    in_valid = 4'b1111; in_dst_x = '0; in_dst_y = '0;
    step();
    step();
    check("rst_pos_torus6", {58'b0, px[2], py[2]}, {58'b0, 3'd2, 3'd1});
    check("rst_valid_mesh", 64'(ov[0]), 64'(0));

    reset = 1'b0; stall = 1'b0; in_valid = '0; set_cfg(1, 3, 3);
    step();
    set_cfg(0, 0, 0);
    in_valid = 4'b0111;
    set_dst(0, 5, 1); set_dst(1, 3, 3); set_dst(2, 0, 7); set_dst(3, 0, 0);
    step();
    check("mesh_ch0_prod", 64'(op[0][4:0]), 64'(5'b01001));
    check("mesh_ch0_valid", 64'(ov[0][0]), 64'(1'b1));
    check("mesh_ch1_local", 64'(op[0][9:5]), 64'(5'b10000));
    check("mesh_ch2_prod", 64'(op[0][14:10]), 64'(5'b00110));

    // Restart so the torus tie bit is known to be 0.
    reset = 1'b1; in_valid = '0;
    step();
    reset = 1'b0; set_cfg(1, 0, 0);
    step();
    set_cfg(0, 0, 0); in_valid = 4'b0001; set_dst(0, 4, 0);
    step();
    check("torus_tie_first", 64'(op[1][4:0]), 64'(5'b00001));
    step();
    check("torus_tie_second", 64'(op[1][4:0]), 64'(5'b00010));

    in_valid = '0; set_cfg(1, 1, 1);
    step();
    set_cfg(0, 0, 0); in_valid = 4'b0011; set_dst(0, 7, 1); set_dst(1, 6, 0);
    step();
    check("torus_wrap", 64'(op[1][4:0]), 64'(5'b00010));
    check("torus6_err", 64'(oe[2][1]), 64'(1'b1));
    check("torus6_err_prod", 64'(op[2][9:5]), 64'(0));

    // Three stalled cycles with changing inputs.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'($urandom_range(0, 15));
      for (int c = 0; c < NC; c++) set_dst(c, $urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end
    check("stall_hold_ch0", 64'(op[1][4:0]), 64'(5'b00010));

    stall = 1'b0; set_cfg(1, 2, 2); in_valid = 4'b0001; set_dst(0, 2, 2);
    step();
    check("cfg_old_pos", 64'(op[0][4:0]), 64'(5'b00101));
    set_cfg(0, 0, 0);
    step();
    check("cfg_new_pos", 64'(op[0][4:0]), 64'(5'b10000));

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      set_cfg($urandom_range(0, 9) == 0, $urandom_range(0, 4), $urandom_range(0, 4));
      in_valid = 4'($urandom_range(0, 15));
      for (int c = 0; c < NC; c++) set_dst(c, $urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
